// File: rtl/count_sequencer.sv
// Command-driven sequencer for a modulo-2^CNT_W Moore counter: runs of cmd_len
// advances paced by a (cmd_div+1)-cycle prescaler, with pause, abort and auto-repeat.
module count_sequencer #(
   parameter int CNT_W = 2,
   parameter int LEN_W = 8,
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [DIV_W-1:0] cmd_div,
   input  logic             cmd_repeat,
   input  logic             pause,
   input  logic             abort,
   output logic [CNT_W-1:0] count,
   output logic             tick,
   output logic             wrap,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [1:0]       dbg_state
);

   // Command handshake: a command transfers on a rising edge where
   // cmd_valid && cmd_ready; cmd_ready is high exactly when the FSM is IDLE.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] remaining;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] prescaler;
   logic             repeat_q;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RUN) || (state == HOLD);
   assign dbg_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         len_q     <= '0;
         remaining <= '0;
         div_q     <= '0;
         prescaler <= '0;
         repeat_q  <= 1'b0;
         count     <= '0;
         tick      <= 1'b0;
         wrap      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         tick    <= 1'b0;
         wrap    <= 1'b0;
         aborted <= 1'b0;
         // done trails the DONE state by one cycle, so it lands after the final tick
         done    <= (state == DONE);
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  len_q     <= cmd_len;
                  div_q     <= cmd_div;
                  repeat_q  <= cmd_repeat;
                  remaining <= cmd_len;
                  prescaler <= '0;
                  count     <= '0;
                  state     <= (cmd_len == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state   <= IDLE;
                  aborted <= 1'b1;
               end else if (pause) begin
                  state <= HOLD;
               end else if (prescaler == div_q) begin
                  count     <= count + CNT_W'(1);
                  tick      <= 1'b1;
                  wrap      <= (count == {CNT_W{1'b1}});
                  prescaler <= '0;
                  if (remaining == LEN_W'(1)) begin
                     if (repeat_q) begin
                        remaining <= len_q;
                     end else begin
                        remaining <= '0;
                        state     <= DONE;
                     end
                  end else begin
                     remaining <= remaining - LEN_W'(1);
                  end
               end else begin
                  prescaler <= prescaler + DIV_W'(1);
               end
            end
            HOLD: begin
               if (abort) begin
                  state   <= IDLE;
                  aborted <= 1'b1;
               end else if (!pause) begin
                  state <= RUN;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: a table of single runs plus hand-built
// repeat/abort, zero-length, pause and mid-run reset sequences, scored against tick timing.
module tb_count_sequencer;

   localparam int CNT_W = 2;
   localparam int LEN_W = 8;
   localparam int DIV_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic [DIV_W-1:0] cmd_div;
   logic             cmd_repeat;
   logic             pause;
   logic             abort;
   logic [CNT_W-1:0] count;
   logic             tick;
   logic             wrap;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [1:0]       dbg_state;

   int checks      = 0;
   int errors      = 0;
   int cyc         = 0;
   int done_cnt    = 0;
   int wrap_cnt    = 0;
   int aborted_cnt = 0;

   // each entry: {cycle at which the tick is visible, expected count}
   logic [33:0] exp_q[$];
   logic [33:0] mon_e;

   typedef struct {
      int len;
      int div;
      int fin;
      int wraps;
   } vec_t;

   vec_t vecs[6];

   count_sequencer #(.CNT_W(CNT_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_len    (cmd_len),
      .cmd_div    (cmd_div),
      .cmd_repeat (cmd_repeat),
      .pause      (pause),
      .abort      (abort),
      .count      (count),
      .tick       (tick),
      .wrap       (wrap),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .dbg_state  (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_tick(input int c, input int n);
      exp_q.push_back({32'(c), 2'(n)});
   endtask

   // scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (aborted) aborted_cnt++;
      if (wrap) wrap_cnt++;
      if (tick) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_tick", tick, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("tick_cycle", cyc, int'(mon_e[33:2]));
            chk("tick_count", count, mon_e[1:0]);
            chk("tick_wrap", wrap, (mon_e[1:0] == 2'd0));
         end
      end else if (wrap) begin
         chk("wrap_without_tick", wrap, 0);
      end
   end

   // driver: returns at the falling edge after acceptance, where cyc == acc
   task automatic send_cmd(input int len, input int div, input int rep, output int acc);
      @(negedge clk);
      for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
      if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1);
      cmd_valid  = 1'b1;
      cmd_len    = LEN_W'(len);
      cmd_div    = DIV_W'(div);
      cmd_repeat = rep[0];
      acc        = cyc + 1;
      @(negedge clk);
      cmd_valid  = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            dcyc = cyc;
            break;
         end
      end
      if (dcyc < 0) chk("done_timeout", done, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int acc;
      int dcyc;
      int w0;
      int d0;
      int a0;

      vecs[0] = '{len: 4, div: 0,  fin: 0, wraps: 1};
      vecs[1] = '{len: 3, div: 2,  fin: 3, wraps: 0};
      vecs[2] = '{len: 5, div: 1,  fin: 1, wraps: 1};
      vecs[3] = '{len: 9, div: 3,  fin: 1, wraps: 2};
      vecs[4] = '{len: 1, div: 15, fin: 1, wraps: 0};
      vecs[5].len   = int'($urandom_range(1, 12));
      vecs[5].div   = int'($urandom_range(0, 3));
      vecs[5].fin   = vecs[5].len % 4;
      vecs[5].wraps = vecs[5].len / 4;

      // reset
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_len    = '0;
      cmd_div    = '0;
      cmd_repeat = 1'b0;
      pause      = 1'b0;
      abort      = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_tick", tick, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_state", dbg_state, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // table-driven single runs
      for (int i = 0; i < 6; i++) begin
         w0 = wrap_cnt;
         send_cmd(vecs[i].len, vecs[i].div, 0, acc);
         for (int k = 1; k <= vecs[i].len; k++) push_tick(acc + k * (vecs[i].div + 1), k % 4);
         chk("run_busy", busy, 1);
         chk("run_state", dbg_state, 1);
         chk("run_ready", cmd_ready, 0);
         wait_done(vecs[i].len * (vecs[i].div + 1) + 20, dcyc);
         chk("done_cycle", dcyc, acc + vecs[i].len * (vecs[i].div + 1) + 1);
         chk("final_count", count, vecs[i].fin);
         chk("wrap_total", wrap_cnt - w0, vecs[i].wraps);
         chk("pending_ticks", exp_q.size(), 0);
         chk("ready_at_done", cmd_ready, 1);
         @(negedge clk);
         chk("done_low", done, 0);
      end

      // repeat run, then abort together with pause
      d0 = done_cnt;
      send_cmd(2, 0, 1, acc);
      for (int k = 1; k <= 10; k++) push_tick(acc + k, k % 4);
      while (cyc < acc + 10) @(negedge clk);
      pause = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      pause = 1'b0;
      abort = 1'b0;
      chk("abort_pulse", aborted, 1);
      chk("abort_busy", busy, 0);
      chk("abort_tick", tick, 0);
      chk("abort_count", count, 2);
      chk("abort_state", dbg_state, 0);
      chk("repeat_no_done", done_cnt - d0, 0);
      chk("repeat_pending", exp_q.size(), 0);
      @(negedge clk);
      chk("abort_pulse_end", aborted, 0);
      chk("abort_count_held", count, 2);

      // zero-length command; a second command held valid while not ready is dropped
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_len    = '0;
      cmd_div    = '0;
      cmd_repeat = 1'b0;
      acc        = cyc + 1;
      @(negedge clk);
      cmd_len = LEN_W'(3);
      chk("zero_ready", cmd_ready, 0);
      chk("zero_busy", busy, 0);
      chk("zero_count", count, 0);
      chk("zero_state", dbg_state, 3);
      @(negedge clk);
      chk("zero_done", done, 1);
      chk("zero_ready_back", cmd_ready, 1);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("zero_done_low", done, 0);
      chk("held_cmd_ignored", busy, 0);
      chk("held_cmd_state", dbg_state, 0);
      chk("zero_count_end", count, 0);

      // pause held for five edges mid-run
      send_cmd(4, 1, 0, acc);
      push_tick(acc + 2, 1);
      push_tick(acc + 10, 2);
      push_tick(acc + 12, 3);
      push_tick(acc + 14, 0);
      while (cyc < acc + 3) @(negedge clk);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_state", dbg_state, 2);
         chk("hold_count", count, 1);
         chk("hold_busy", busy, 1);
      end
      pause = 1'b0;
      wait_done(30, dcyc);
      chk("pause_done_cycle", dcyc, acc + 15);
      chk("pause_final_count", count, 0);
      chk("pause_pending", exp_q.size(), 0);

      // asynchronous reset in the middle of a run
      send_cmd(8, 3, 0, acc);
      push_tick(acc + 4, 1);
      push_tick(acc + 8, 2);
      while (cyc < acc + 9) @(negedge clk);
      chk("pre_reset_count", count, 2);
      d0 = done_cnt;
      a0 = aborted_cnt;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_ready", cmd_ready, 1);
      chk("async_rst_state", dbg_state, 0);
      chk("async_rst_done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("post_rst_no_done", done_cnt - d0, 0);
      chk("post_rst_no_abort", aborted_cnt - a0, 0);
      chk("post_rst_count", count, 0);
      chk("post_rst_state", dbg_state, 0);
      chk("post_rst_pending", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
